// File: rtl/mult_pkg.sv
// Shared constants and helpers for the iterative radix-4 Booth multiplier.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned MULT_ITER  = MULT_WIDTH / 2;
  localparam int unsigned MULT_PW    = 2 * MULT_WIDTH + 3;
  localparam int unsigned MULT_HW    = MULT_WIDTH + 2;

  function automatic logic [MULT_HW-1:0] sext34(input logic [MULT_WIDTH-1:0] v);
    return {{(MULT_HW - MULT_WIDTH){v[MULT_WIDTH-1]}}, v};
  endfunction

endpackage

// File: rtl/booth_addsub34.sv
// 34-bit modulo add/subtract used for the Booth partial-product accumulation.
module booth_addsub34
  import mult_pkg::*;
(
  input  logic [MULT_HW-1:0] a,
  input  logic [MULT_HW-1:0] b,
  input  logic               sub,
  output logic [MULT_HW-1:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/mult_datapath.sv
// Iterative signed radix-4 Booth multiplier datapath; the Booth window and
// per-cycle decode are exchanged with an external controller.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned ITER  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             init_cycle,
  input  logic             finish_cyc,
  input  logic             mltnd_shift,
  input  logic             sub,
  input  logic             zero,
  output logic [2:0]       bits,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned PW = 2 * WIDTH + 3;
  localparam int unsigned HW = WIDTH + 2;
  localparam int unsigned CW = $clog2(ITER + 1);

  logic [WIDTH-1:0] opa_q, opb_q, m_q, result_q;
  logic [PW-1:0]    p_q, p_shift;
  logic [CW-1:0]    iter_q;
  logic             busy_q, rdy_q, exc_q;
  logic [HW-1:0]    h, partial, hn;
  logic [WIDTH:0]   top_bits;
  logic             do_init, do_iter, do_finish;

  assign h = p_q[PW-1:WIDTH+1];

  always_comb begin
    partial = '0;
    if (!zero) begin
      partial = mltnd_shift ? (sext34(m_q) << 1) : sext34(m_q);
    end
  end

  booth_addsub34 u_addsub (
    .a   (h),
    .b   (partial),
    .sub (sub),
    .sum (hn)
  );

  assign p_shift = $signed({hn, p_q[WIDTH:0]}) >>> 2;

  // start_mult overrides every controller marker in the same cycle.
  assign do_init   = busy_q & init_cycle & ~start_mult;
  assign do_finish = busy_q & finish_cyc & ~start_mult;
  assign do_iter   = busy_q & ~start_mult & ~init_cycle & ~finish_cyc
                   & (iter_q < CW'(ITER));

  // Product fits in WIDTH signed bits iff the upper half matches the result sign.
  assign top_bits = p_q[2*WIDTH:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      m_q      <= '0;
      p_q      <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      exc_q    <= 1'b0;
      result_q <= '0;
    end else begin
      rdy_q <= 1'b0;
      if (start_mult) begin
        opa_q  <= data_operandA;
        opb_q  <= data_operandB;
        busy_q <= 1'b1;
        iter_q <= '0;
      end else begin
        if (do_init) begin
          m_q <= opa_q;
          p_q <= {{HW{1'b0}}, opb_q, 1'b0};
        end else if (do_iter) begin
          p_q    <= p_shift;
          iter_q <= iter_q + 1'b1;
        end
        if (do_finish) begin
          result_q <= p_q[WIDTH:1];
          exc_q    <= ~((&top_bits) | ~(|top_bits));
          rdy_q    <= 1'b1;
          busy_q   <= 1'b0;
        end
      end
    end
  end

  assign bits           = p_q[2:0];
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
